stack_frame_master: RTL and testbench

//   Initiator side of the 11-bit LIFO stack port. Accepts frame-level commands
//   (push N words, pop N words, peek top) on a valid/ready interface and drives
//   the stack's push/top/pop strobes one word per cycle. Gathers popped words

---
 rtl/stack_frame_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_stack_frame_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_frame_master.sv
// Frame-level push/pop/peek engine for an 11-bit LIFO stack: moves one word per cycle,
// re-assembles popped words into frame order and tracks occupancy so the stack never wraps.
module stack_frame_master #(
    parameter int DATA_W  = 11,
    parameter int DEPTH   = 32,
    parameter int MAX_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [2:0]                 cmd_len,
    input  logic [MAX_LEN*DATA_W-1:0]  cmd_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_err,
    output logic [MAX_LEN*DATA_W-1:0]  rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       sync_err,
    output logic [DATA_W-1:0]          stk_d_in,
    output logic                       stk_push,
    output logic                       stk_top,
    output logic                       stk_pop,
    input  logic                       stk_empty,
    input  logic [DATA_W-1:0]          stk_d_out
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int LEN_W = 3;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_DRAIN, S_PEEK, S_RESP} state_t;

    state_t              r_state, w_state_next;
    logic                r_cmd_ready, w_cmd_ready_next;
    logic                r_rsp_valid, w_rsp_valid_next;
    logic                r_rsp_err, w_rsp_err_next;
    logic [OCC_W-1:0]    r_occ, w_occ_next;
    logic                r_sync_err, w_sync_err_next;
    logic [DATA_W-1:0]   r_stk_d_in, w_stk_d_in_next;
    logic                r_stk_push, w_stk_push_next;
    logic                r_stk_top, w_stk_top_next;
    logic                r_stk_pop, w_stk_pop_next;
    logic [LEN_W-1:0]    r_len, w_len_next;
    logic [LEN_W-1:0]    r_idx, w_idx_next;
    logic                r_cap_en, w_cap_en_next;
    logic [IDX_W-1:0]    r_cap_slot, w_cap_slot_next;
    logic [DATA_W-1:0]   r_frame [MAX_LEN];
    logic [DATA_W-1:0]   w_frame_next [MAX_LEN];
    logic [DATA_W-1:0]   r_rsp_word [MAX_LEN];
    logic [DATA_W-1:0]   w_rsp_word_next [MAX_LEN];

    logic                w_accept;
    logic                w_cmd_err;
    logic                w_len_bad;
    logic [OCC_W:0]      w_occ_sum;
    logic                w_push_ovf;
    logic                w_pop_unf;
    logic [LEN_W-1:0]    w_idx_inc;
    logic                w_last;
    logic [LEN_W-1:0]    w_pop_slot;

    assign w_accept   = cmd_valid & r_cmd_ready;
    assign w_len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
    assign w_occ_sum  = {1'b0, r_occ} + (OCC_W+1)'(cmd_len);
    assign w_push_ovf = w_occ_sum > (OCC_W+1)'(DEPTH);
    assign w_pop_unf  = OCC_W'(cmd_len) > r_occ;
    assign w_idx_inc  = r_idx + LEN_W'(1);
    assign w_last     = (w_idx_inc >= r_len);
    // The k-th popped word lands in slot len-1-k so the frame comes back in push order.
    assign w_pop_slot = r_len - LEN_W'(1) - r_idx;

    always_comb begin
        unique case (cmd_op)
            2'b00:   w_cmd_err = w_len_bad | w_push_ovf;
            2'b01:   w_cmd_err = w_len_bad | w_pop_unf;
            2'b10:   w_cmd_err = (r_occ == '0);
            default: w_cmd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_occ       <= '0;
            r_sync_err  <= 1'b0;
            r_stk_d_in  <= '0;
            r_stk_push  <= 1'b0;
            r_stk_top   <= 1'b0;
            r_stk_pop   <= 1'b0;
            r_len       <= '0;
            r_idx       <= '0;
            r_cap_en    <= 1'b0;
            r_cap_slot  <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_frame[i]    <= '0;
                r_rsp_word[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_err   <= w_rsp_err_next;
            r_occ       <= w_occ_next;
            r_sync_err  <= w_sync_err_next;
            r_stk_d_in  <= w_stk_d_in_next;
            r_stk_push  <= w_stk_push_next;
            r_stk_top   <= w_stk_top_next;
            r_stk_pop   <= w_stk_pop_next;
            r_len       <= w_len_next;
            r_idx       <= w_idx_next;
            r_cap_en    <= w_cap_en_next;
            r_cap_slot  <= w_cap_slot_next;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_frame[i]    <= w_frame_next[i];
                r_rsp_word[i] <= w_rsp_word_next[i];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_err)             w_state_next = S_RESP;
                    else if (cmd_op == 2'b00)  w_state_next = S_PUSH;
                    else if (cmd_op == 2'b01)  w_state_next = S_POP;
                    else                       w_state_next = S_PEEK;
                end
            end
            S_PUSH:  if (w_last) w_state_next = S_RESP;
            S_POP:   if (w_last) w_state_next = S_DRAIN;
            S_PEEK:  w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready_next = r_cmd_ready;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_err_next   = r_rsp_err;
        w_stk_d_in_next  = '0;
        w_stk_push_next  = 1'b0;
        w_stk_top_next   = 1'b0;
        w_stk_pop_next   = 1'b0;
        w_len_next       = r_len;
        w_idx_next       = r_idx;
        w_cap_en_next    = 1'b0;
        w_cap_slot_next  = r_cap_slot;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_frame_next[i]    = r_frame[i];
            w_rsp_word_next[i] = r_rsp_word[i];
        end
        if (r_cap_en)
            w_rsp_word_next[r_cap_slot] = stk_d_out;

        w_occ_next = r_occ;
        if (r_stk_push)     w_occ_next = r_occ + OCC_W'(1);
        else if (r_stk_pop) w_occ_next = r_occ - OCC_W'(1);
        w_sync_err_next = r_sync_err | ((r_state == S_IDLE) && (stk_empty != (r_occ == '0)));

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cmd_ready_next = 1'b0;
                    w_len_next       = cmd_len;
                    w_idx_next       = '0;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        w_frame_next[i]    = cmd_data[i*DATA_W +: DATA_W];
                        w_rsp_word_next[i] = '0;
                    end
                    if (w_cmd_err) begin
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                    end else if (cmd_op == 2'b00) begin
                        w_stk_push_next = 1'b1;
                        w_stk_d_in_next = cmd_data[DATA_W-1:0];
                    end else if (cmd_op == 2'b01) begin
                        w_stk_pop_next = 1'b1;
                    end else begin
                        w_stk_top_next = 1'b1;
                    end
                end
            end
            S_PUSH: begin
                w_idx_next = w_idx_inc;
                if (w_last) begin
                    w_rsp_valid_next = 1'b1;
                end else begin
                    w_stk_push_next = 1'b1;
                    w_stk_d_in_next = r_frame[w_idx_inc[IDX_W-1:0]];
                end
            end
            S_POP: begin
                // Stack data for this pop appears next cycle; capture it then.
                w_cap_en_next   = 1'b1;
                w_cap_slot_next = w_pop_slot[IDX_W-1:0];
                w_idx_next      = w_idx_inc;
                if (!w_last) w_stk_pop_next = 1'b1;
            end
            S_PEEK: begin
                w_cap_en_next   = 1'b1;
                w_cap_slot_next = '0;
            end
            S_DRAIN: w_rsp_valid_next = 1'b1;
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_rsp_err_next   = 1'b0;
                    w_cmd_ready_next = 1'b1;
                    for (int i = 0; i < MAX_LEN; i++) w_rsp_word_next[i] = '0;
                end
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_slot
            assign rsp_data[gi*DATA_W +: DATA_W] = r_rsp_word[gi];
        end
    endgenerate

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign occupancy = r_occ;
    assign sync_err  = r_sync_err;
    assign stk_d_in  = r_stk_d_in;
    assign stk_push  = r_stk_push;
    assign stk_top   = r_stk_top;
    assign stk_pop   = r_stk_pop;
endmodule

// File: tb/tb_stack_frame_master.sv
// Directed bench for stack_frame_master: a behavioural LIFO sits on the stack port and
// a scoreboard of expected responses is filled as commands are issued.
module tb_stack_frame_master;
    localparam int DW = 11;
    localparam int DEPTH = 32;
    localparam int ML = 4;
    localparam int FW = ML * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [2:0]    cmd_len = '0;
    logic [FW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_err;
    logic [FW-1:0] rsp_data;
    logic [5:0]    occupancy;
    logic          sync_err;
    logic [DW-1:0] stk_d_in;
    logic          stk_push, stk_top, stk_pop;
    logic          stk_empty;
    logic [DW-1:0] stk_d_out;

    typedef struct packed {
        logic          err;
        logic [FW-1:0] data;
        logic [5:0]    occ;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl[$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    stack_frame_master #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_LEN(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .occupancy(occupancy), .sync_err(sync_err),
        .stk_d_in(stk_d_in), .stk_push(stk_push), .stk_top(stk_top),
        .stk_pop(stk_pop), .stk_empty(stk_empty), .stk_d_out(stk_d_out)
    );

    // Behavioural stack: read data valid the cycle after top/pop, reset together with the DUT.
    logic [DW-1:0] stk_mem [DEPTH];
    logic [5:0]    stk_sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_sp    <= '0;
            stk_d_out <= '0;
        end else if (stk_push) begin
            stk_mem[stk_sp[4:0]] <= stk_d_in;
            stk_sp <= stk_sp + 6'd1;
        end else if (stk_top) begin
            stk_d_out <= stk_mem[5'(stk_sp - 6'd1)];
        end else if (stk_pop) begin
            stk_d_out <= stk_mem[5'(stk_sp - 6'd1)];
            stk_sp <= stk_sp - 6'd1;
        end
    end
    assign stk_empty = (stk_sp == 6'd0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [FW-1:0] data,
                           input int hold);
        exp_t          e;
        bit            err;
        int            occ, lat, xpush, xpop, xtop, cyc, npush, npop, ntop;
        logic [FW-1:0] held;
        occ = mdl.size();
        e.data = '0;
        xpush = 0; xpop = 0; xtop = 0; lat = 1;
        case (op)
            2'b00: begin
                err = (len < 1) || (len > ML) || (occ + len > DEPTH);
                if (!err) begin
                    for (int k = 0; k < len; k++) mdl.push_back(data[k*DW +: DW]);
                    xpush = len; lat = len + 1;
                end
            end
            2'b01: begin
                err = (len < 1) || (len > ML) || (len > occ);
                if (!err) begin
                    for (int j = 0; j < len; j++) e.data[j*DW +: DW] = mdl[occ-len+j];
                    for (int j = 0; j < len; j++) void'(mdl.pop_back());
                    xpop = len; lat = len + 2;
                end
            end
            2'b10: begin
                err = (occ == 0);
                if (!err) begin
                    e.data[DW-1:0] = mdl[occ-1];
                    xtop = 1; lat = 3;
                end
            end
            default: err = 1'b1;
        endcase
        e.err = err;
        e.occ = 6'(mdl.size());
        sb.push_back(e);

        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 3'(len); cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = '0;
        cyc = 1; npush = 0; npop = 0; ntop = 0;
        while (!rsp_valid && cyc < 40) begin
            check("one_strobe", 64'($onehot0({stk_push, stk_pop, stk_top})), 64'd1);
            if (stk_push) begin
                check("push_cycle", 64'(cyc), 64'(npush + 1));
                check("push_d_in", 64'(stk_d_in), 64'(data[(npush % ML)*DW +: DW]));
                npush++;
            end
            if (stk_pop) begin
                check("pop_cycle", 64'(cyc), 64'(npop + 1));
                npop++;
            end
            if (stk_top) begin
                check("top_cycle", 64'(cyc), 64'd1);
                ntop++;
            end
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", 64'(cyc), 64'(lat));
        check("n_push", 64'(npush), 64'(xpush));
        check("n_pop", 64'(npop), 64'(xpop));
        check("n_top", 64'(ntop), 64'(xtop));

        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = i[0]; cmd_op = 2'b00; cmd_len = 3'd1; cmd_data = 44'h5A5;
            @(negedge clk);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_data", 64'(rsp_data), 64'(held));
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 1'b0; cmd_data = '0;

        rsp_ready = 1'b1;
        e = sb.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("occupancy", 64'(occupancy), 64'(e.occ));
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", 64'(rsp_valid), 64'd0);
        check("back_idle", 64'(cmd_ready), 64'd1);
        $display("cmd op=%0d len=%0d err=%0b data=%0h occ=%0d", op, len, rsp_err, e.data, occupancy);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_occ"}, 64'(occupancy), 64'd0);
        check({tag, "_strobes"}, 64'({stk_push, stk_pop, stk_top}), 64'd0);
        check({tag, "_d_in"}, 64'(stk_d_in), 64'd0);
        check({tag, "_sync_err"}, 64'(sync_err), 64'd0);
    endtask

    initial begin
        logic [FW-1:0] frame;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        run_cmd(2'b00, 3, {11'h000, 11'h003, 11'h002, 11'h001}, 0);
        run_cmd(2'b01, 3, '0, 0);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < ML; k++) frame[k*DW +: DW] = 11'($urandom);
            run_cmd(2'b00, 4, frame, 0);
        end
        run_cmd(2'b00, 1, 44'h1, 0);         // full stack rejects
        for (int f = 0; f < 8; f++) run_cmd(2'b01, 4, '0, 0);

        run_cmd(2'b10, 0, '0, 0);            // peek on empty
        run_cmd(2'b00, 1, 44'h7FF, 0);
        run_cmd(2'b10, 0, '0, 5);            // peek with stalled response
        run_cmd(2'b11, 2, '0, 0);
        run_cmd(2'b01, 0, '0, 0);
        run_cmd(2'b01, 5, '0, 0);
        run_cmd(2'b01, 2, '0, 0);
        run_cmd(2'b00, 0, '0, 0);
        run_cmd(2'b00, 5, '0, 0);
        run_cmd(2'b01, 1, '0, 2);
        check("sync_err_clean", 64'(sync_err), 64'd0);

        // Reset in the middle of a POP frame.
        run_cmd(2'b00, 4, {11'h444, 11'h333, 11'h222, 11'h111}, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midpop_strobe_c1", 64'(stk_pop), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midpop_strobes", 64'({stk_push, stk_pop, stk_top}), 64'd0);
        check("midpop_occ", 64'(occupancy), 64'd0);
        check("midpop_rsp_valid", 64'(rsp_valid), 64'd0);
        mdl.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_midpop");
        $display("mid-frame reset applied");

        run_cmd(2'b00, 2, {22'h0, 11'h0AB, 11'h0CD}, 0);
        run_cmd(2'b01, 2, '0, 0);
        check("sync_err_final", 64'(sync_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
